// File: rtl/clk_meter.sv
// Measures period and high time of an asynchronous square wave in clk_in cycles,
// with a sticky timeout when no rising edge arrives within TIMEOUT cycles.
module clk_meter #(
    parameter int CNT_W       = 32,
    parameter int TIMEOUT     = 1000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                                 input logic             inc);
        logic [CNT_W-1:0] result;
        if (inc && (value != CNT_MAX)) begin
            result = value + CNT_ONE;
        end else begin
            result = value;
        end
        return result;
    endfunction

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sig_d_r;
    logic                   sig_s;
    logic                   rise_s;

    state_t           state_r, state_nx_s;
    logic [CNT_W-1:0] cnt_r, cnt_nx_s;
    logic [CNT_W-1:0] hcnt_r, hcnt_nx_s;
    logic [CNT_W-1:0] period_r, period_nx_s;
    logic [CNT_W-1:0] high_r, high_nx_s;
    logic             valid_r, valid_nx_s;
    logic             locked_r, locked_nx_s;
    logic             timeout_r, timeout_nx_s;

    assign sig_s  = sync_r[SYNC_STAGES-1];
    assign rise_s = sig_s & ~sig_d_r;

    // Synchroniser chain and one-cycle delay for edge detection
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            sync_r  <= {SYNC_STAGES{1'b0}};
            sig_d_r <= 1'b0;
        end else begin
            sync_r  <= {sync_r[SYNC_STAGES-2:0], sig_in};
            sig_d_r <= sig_s;
        end
    end

    // Next-state and datapath decisions; enable low overrides every transition
    always_comb begin
        state_nx_s   = state_r;
        cnt_nx_s     = cnt_r;
        hcnt_nx_s    = hcnt_r;
        period_nx_s  = period_r;
        high_nx_s    = high_r;
        valid_nx_s   = 1'b0;
        locked_nx_s  = locked_r;
        timeout_nx_s = timeout_r;
        if (!enable) begin
            state_nx_s   = ST_IDLE;
            cnt_nx_s     = CNT_ZERO;
            hcnt_nx_s    = CNT_ZERO;
            locked_nx_s  = 1'b0;
            timeout_nx_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nx_s = ST_ARM;
                    cnt_nx_s   = CNT_ZERO;
                    hcnt_nx_s  = CNT_ZERO;
                end
                ST_ARM: begin
                    // The first edge only sets the reference point; nothing to report yet
                    if (rise_s) begin
                        state_nx_s   = ST_MEAS;
                        cnt_nx_s     = CNT_ONE;
                        hcnt_nx_s    = CNT_ONE;
                        timeout_nx_s = 1'b0;
                    end else if (cnt_r == TIMEOUT_C) begin
                        state_nx_s   = ST_ARM;
                        cnt_nx_s     = CNT_ZERO;
                        timeout_nx_s = 1'b1;
                        locked_nx_s  = 1'b0;
                    end else begin
                        cnt_nx_s = sat_inc(cnt_r, 1'b1);
                    end
                end
                ST_MEAS: begin
                    if (rise_s) begin
                        period_nx_s = cnt_r;
                        high_nx_s   = hcnt_r;
                        valid_nx_s  = 1'b1;
                        locked_nx_s = 1'b1;
                        cnt_nx_s    = CNT_ONE;
                        hcnt_nx_s   = CNT_ONE;
                    end else if (cnt_r == TIMEOUT_C) begin
                        state_nx_s   = ST_ARM;
                        cnt_nx_s     = CNT_ZERO;
                        timeout_nx_s = 1'b1;
                        locked_nx_s  = 1'b0;
                    end else begin
                        cnt_nx_s  = sat_inc(cnt_r, 1'b1);
                        hcnt_nx_s = sat_inc(hcnt_r, sig_s);
                    end
                end
                default: begin
                    state_nx_s   = ST_IDLE;
                    cnt_nx_s     = CNT_ZERO;
                    hcnt_nx_s    = CNT_ZERO;
                    locked_nx_s  = 1'b0;
                    timeout_nx_s = 1'b0;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Counters and registered outputs
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            cnt_r     <= CNT_ZERO;
            hcnt_r    <= CNT_ZERO;
            period_r  <= CNT_ZERO;
            high_r    <= CNT_ZERO;
            valid_r   <= 1'b0;
            locked_r  <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            cnt_r     <= cnt_nx_s;
            hcnt_r    <= hcnt_nx_s;
            period_r  <= period_nx_s;
            high_r    <= high_nx_s;
            valid_r   <= valid_nx_s;
            locked_r  <= locked_nx_s;
            timeout_r <= timeout_nx_s;
        end
    end

    assign period     = period_r;
    assign high_time  = high_r;
    assign meas_valid = valid_r;
    assign locked     = locked_r;
    assign timeout    = timeout_r;

endmodule

// File: tb/tb_clk_meter.sv
// Scoreboard bench for clk_meter: an event/elapsed-time reference model queues
// expected measurements; a negedge monitor pops them when meas_valid appears.
module tb_clk_meter;

    localparam int CNT_W = 16;
    localparam int TO    = 100;
    localparam int SS    = 2;
    localparam int MAXC  = 20000;

    logic             clk_in = 1'b0;
    logic             reset  = 1'b0;
    logic             enable = 1'b0;
    logic             sig_in = 1'b0;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             timeout;

    clk_meter #(.CNT_W(CNT_W), .TIMEOUT(TO), .SYNC_STAGES(SS)) dut (
        .clk_in(clk_in), .reset(reset), .enable(enable), .sig_in(sig_in),
        .period(period), .high_time(high_time), .meas_valid(meas_valid),
        .locked(locked), .timeout(timeout)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int due;
        int per;
        int hi;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Reference model: sig_s history, the cycle of the last reference rise and
    // the start of the current arm window; measurements come from plain sums.
    logic m_sync [SS];
    logic m_sd = 1'b0;
    bit   s_hist [MAXC];
    bit   m_active = 1'b0;
    bit   m_have_ref = 1'b0;
    int   m_ref = 0;
    int   m_arm = 0;
    int   m_locked = 0;
    int   m_timeout = 0;
    int   m_period = 0;
    int   m_high = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_edge(input logic x, input logic en, input logic rn);
        int  c;
        int  hi;
        int  elapsed;
        logic s_c;
        logic rise;
        c    = cyc - 1;
        s_c  = m_sync[SS-1];
        rise = s_c && !m_sd;
        if (c >= 0 && c < MAXC) s_hist[c] = s_c;
        if (!rn) begin
            for (int k = 0; k < SS; k++) m_sync[k] = 1'b0;
            m_sd = 1'b0; m_active = 1'b0; m_have_ref = 1'b0;
            m_locked = 0; m_timeout = 0; m_period = 0; m_high = 0;
        end else begin
            m_sd = s_c;
            for (int k = SS - 1; k > 0; k--) m_sync[k] = m_sync[k-1];
            m_sync[0] = x;
            if (!en) begin
                m_active = 1'b0; m_have_ref = 1'b0; m_locked = 0; m_timeout = 0;
            end else if (!m_active) begin
                m_active = 1'b1; m_have_ref = 1'b0; m_arm = cyc;
            end else if (rise) begin
                if (m_have_ref) begin
                    hi = 0;
                    for (int k = m_ref; k < c; k++) hi += int'(s_hist[k]);
                    m_period = c - m_ref;
                    m_high   = hi;
                    m_locked = 1;
                    sb_q.push_back('{cyc, c - m_ref, hi});
                end
                m_have_ref = 1'b1; m_ref = c; m_timeout = 0;
            end else begin
                elapsed = m_have_ref ? (c - m_ref) : (c - m_arm);
                if (elapsed == TO) begin
                    m_timeout = 1; m_locked = 0; m_have_ref = 1'b0; m_arm = cyc;
                end
            end
        end
    endtask

    task automatic step(input logic x, input logic en, input logic rn);
        sig_in = x; enable = en; reset = rn;
        @(posedge clk_in);
        cyc++;
        model_edge(x, en, rn);
        #1;
    endtask

    task automatic gen(input int hi, input int lo, input int n,
                       input int off_at, input int off_len, input int rst_at);
        for (int i = 0; i < n; i++) begin
            step(((i % (hi + lo)) < hi), !(i >= off_at && i < off_at + off_len), i != rst_at);
        end
    endtask

    // Monitor: compare DUT outputs against the scoreboard and model flags
    always @(negedge clk_in) begin
        if (cyc > 0) begin
            while (sb_q.size() > 0 && sb_q[0].due < cyc) void'(sb_q.pop_front());
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                mon_e = sb_q.pop_front();
                check("meas_valid", int'(meas_valid), 1);
                check("period", int'(period), mon_e.per);
                check("high_time", int'(high_time), mon_e.hi);
            end else begin
                check("meas_valid", int'(meas_valid), 0);
            end
            check("locked", int'(locked), m_locked);
            check("timeout", int'(timeout), m_timeout);
            check("period_hold", int'(period), m_period);
            check("high_hold", int'(high_time), m_high);
        end
    end

    initial begin
        int hi, lo, n, off_at, rst_at;
        for (int k = 0; k < SS; k++) m_sync[k] = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        gen(5, 5, 70, -1, 0, -1);       // divide-by-10
        gen(3, 5, 48, -1, 0, -1);       // 3 high / 5 low
        gen(1, 100, 130, -1, 0, -1);    // one rise then stuck low -> timeout
        gen(5, 5, 50, -1, 0, -1);       // recovery at period 10
        gen(6, 6, 72, 42, 3, -1);       // enable low mid-period of 12
        gen(5, 5, 60, -1, 0, 33);       // one-cycle reset mid-measurement
        gen(1, 1, 20, -1, 0, -1);       // fastest input: period 2
        gen(50, 50, 400, -1, 0, -1);    // period exactly TIMEOUT
        gen(150, 0, 150, -1, 0, -1);    // stuck high
        for (int r = 0; r < 12; r++) begin
            hi     = $urandom_range(1, 15);
            lo     = $urandom_range(1, 15);
            n      = (hi + lo) * $urandom_range(3, 6);
            off_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            rst_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, n - 1) : -1;
            gen(hi, lo, n, off_at, 3, rst_at);
        end
        gen(1, 1, 10, -1, 0, -1);
        @(negedge clk_in);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
